// File: rtl/pair_pack_pkg.sv
// Shared types and defaults for the pair packing arbiter.
package pair_pack_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

    // First member is the most significant field, so high lands in [15:8].
    typedef struct packed {
        logic [7:0] high;
        logic [7:0] low;
    } pair_t;

    typedef enum logic [1:0] {
        IDLE,
        HAVE_HIGH,
        OUT
    } state_t;

endpackage

// File: rtl/pair_pack_arbiter_rr.sv
// Two-requester round-robin grant with a 1-bit priority pointer.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = rr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Any grant is a transfer since grants are only given to valid requesters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= 1'b0;
        end else if (gnt != 2'b00) begin
            rr <= ~gnt[1];
        end
    end

endmodule

// File: rtl/pair_pack_arbiter.sv
// Collects bytes from two requesters into high/low pairs, closing a pair early on timeout.
module pair_pack_arbiter
    import pair_pack_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  in_valid,
    input  logic [7:0]  in_data0,
    input  logic [7:0]  in_data1,
    output logic [1:0]  in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [7:0]  out_sum,
    output logic        out_partial,
    output logic [1:0]  out_src
);

    state_t     state, state_d;
    logic [7:0] cnt;
    logic [7:0] hi_q;
    logic       hi_src;
    pair_t      pair_q;
    logic [1:0] gnt;
    logic       xfer;
    logic       gidx;
    logic [7:0] byte_in;
    logic       cnt_last;
    logic       cap_hi;
    logic       cap_lo;
    logic       tmo;

    // Gating with rst_n keeps in_ready low while reset is held.
    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rst_n && (state != OUT)),
        .req   (in_valid),
        .gnt   (gnt)
    );

    assign in_ready = gnt;
    assign xfer     = (gnt != 2'b00);
    assign gidx     = gnt[1];
    assign byte_in  = gidx ? in_data1 : in_data0;
    assign cnt_last = (cnt == 8'(TIMEOUT - 1));

    always_comb begin
        state_d = state;
        cap_hi  = 1'b0;
        cap_lo  = 1'b0;
        tmo     = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    cap_hi  = 1'b1;
                    state_d = HAVE_HIGH;
                end
            end
            HAVE_HIGH: begin
                if (xfer) begin
                    cap_lo  = 1'b1;
                    state_d = OUT;
                end else if (cnt_last) begin
                    tmo     = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            hi_q        <= '0;
            hi_src      <= 1'b0;
            pair_q      <= '0;
            out_valid   <= 1'b0;
            out_partial <= 1'b0;
            out_src     <= '0;
        end else begin
            state <= state_d;
            if (cap_hi) begin
                hi_q   <= byte_in;
                hi_src <= gidx;
                cnt    <= '0;
            end else if (state == HAVE_HIGH && !cap_lo && !tmo) begin
                cnt <= cnt + 8'd1;
            end
            if (cap_lo) begin
                pair_q      <= '{high: hi_q, low: byte_in};
                out_src     <= {hi_src, gidx};
                out_partial <= 1'b0;
                out_valid   <= 1'b1;
            end else if (tmo) begin
                pair_q      <= '{high: hi_q, low: 8'h00};
                out_src     <= {hi_src, 1'b0};
                out_partial <= 1'b1;
                out_valid   <= 1'b1;
            end else if (state == OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_data = pair_q;
    assign out_sum  = pair_q.high + pair_q.low;

endmodule

// File: tb/tb_pair_pack_arbiter.sv
// Directed bench for pair_pack_arbiter with hand-computed expectations.
module tb_pair_pack_arbiter;

    localparam int unsigned TO = 16;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [7:0]  in_data0;
    logic [7:0]  in_data1;
    logic [1:0]  in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_sum;
    logic        out_partial;
    logic [1:0]  out_src;

    int n_checks = 0;
    int n_pass   = 0;

    pair_pack_arbiter #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data0    (in_data0),
        .in_data1    (in_data1),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sum     (out_sum),
        .out_partial (out_partial),
        .out_src     (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
        in_valid = v;
        in_data0 = d0;
        in_data1 = d1;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] d, input logic [7:0] s,
                           input logic [1:0] src, input logic part);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        chk({tag, "_sum"}, 32'(out_sum), 32'(s));
        chk({tag, "_src"}, 32'(out_src), 32'(src));
        chk({tag, "_partial"}, 32'(out_partial), 32'(part));
    endtask

    task automatic accept();
        out_ready = 1'b1;
        #1;
        chk("accept_ready_low", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        chk("accept_valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(2'b11, 8'h00, 8'h00);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_partial", 32'(out_partial), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        drive(2'b00, 8'h00, 8'h00);
        tick();
        rst_n = 1'b1;

        // requester 0 only: 12 then 34
        drive(2'b01, 8'h12, 8'h00);
        chk("a_gnt0", 32'(in_ready), 32'd1);
        tick();
        drive(2'b01, 8'h34, 8'h00);
        chk("a_gnt1", 32'(in_ready), 32'd1);
        tick();
        drive(2'b01, 8'h00, 8'h00);
        chk("a_out_ready0", 32'(in_ready), 32'd0);
        chk_out("a", 16'h1234, 8'h46, 2'b00, 1'b0);
        drive(2'b00, 8'h00, 8'h00);
        accept();

        // fresh reset so rr=0, then both requesters valid
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        drive(2'b11, 8'hA0, 8'h0B);
        chk("b_gnt_first", 32'(in_ready), 32'd1);
        tick();
        chk("b_gnt_second", 32'(in_ready), 32'd2);
        tick();
        chk("b_out_ready0", 32'(in_ready), 32'd0);
        chk_out("b1", 16'hA00B, 8'hAB, 2'b01, 1'b0);
        accept();
        #1;
        chk("b_gnt_third", 32'(in_ready), 32'd1);
        tick();
        chk("b_gnt_fourth", 32'(in_ready), 32'd2);
        tick();
        chk_out("b2", 16'hA00B, 8'hAB, 2'b01, 1'b0);
        drive(2'b00, 8'h00, 8'h00);
        accept();

        // single byte FF from requester 1, then timeout
        drive(2'b10, 8'h00, 8'hFF);
        chk("c_gnt", 32'(in_ready), 32'd2);
        tick();
        drive(2'b00, 8'h00, 8'h00);
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        chk("c_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk_out("c", 16'hFF00, 8'hFF, 2'b10, 1'b1);
        accept();

        // second byte lands exactly in the timeout cycle
        drive(2'b01, 8'h55, 8'h00);
        tick();
        drive(2'b00, 8'h00, 8'h00);
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        chk("d_not_yet", 32'(out_valid), 32'd0);
        drive(2'b10, 8'h00, 8'h22);
        chk("d_gnt", 32'(in_ready), 32'd2);
        tick();
        chk_out("d", 16'h5522, 8'h77, 2'b01, 1'b0);

        // back-pressure: hold out_ready low for 5 cycles
        drive(2'b11, 8'h66, 8'h77);
        for (int i = 0; i < 5; i++) begin
            chk("e_hold_ready", 32'(in_ready), 32'd0);
            chk("e_hold_data", 32'(out_data), 32'h5522);
            chk("e_hold_valid", 32'(out_valid), 32'd1);
            tick();
        end
        accept();
        #1;
        chk("e_next_gnt", 32'(in_ready), 32'd1);
        drive(2'b00, 8'h00, 8'h00);

        // reset while holding a high byte
        drive(2'b01, 8'h99, 8'h00);
        tick();
        chk("f_in_have_high", 32'(out_valid), 32'd0);
        drive(2'b11, 8'h99, 8'h99);
        rst_n = 1'b0;
        #1;
        chk("f_rst_ready", 32'(in_ready), 32'd0);
        chk("f_rst_valid", 32'(out_valid), 32'd0);
        chk("f_rst_data", 32'(out_data), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(2'b00, 8'h00, 8'h00);
        tick();
        tick();
        chk("f_no_stale", 32'(out_valid), 32'd0);
        drive(2'b11, 8'hC3, 8'h3C);
        chk("f_gnt_rr0", 32'(in_ready), 32'd1);
        tick();
        tick();
        drive(2'b00, 8'h00, 8'h00);
        chk_out("f", 16'hC33C, 8'hFF, 2'b01, 1'b0);
        accept();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
